// File: rtl/fetch_redirect_unit.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding
// imem requests, holds the IF/ID register and resolves decode redirects.
module fetch_redirect_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    input  logic        stall_in,
    input  logic        dec_valid,
    input  logic [15:0] dec_instr,
    input  logic [15:0] rs_val,
    input  logic [15:0] brj_dest,
    input  logic [15:0] jr_dest,
    output logic [15:0] pc,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_inc,
    output logic        if_valid,
    output logic        flush,
    output logic        halted
);

    localparam int unsigned XLEN = 16;
    localparam int unsigned OPW  = 5;

    localparam logic [OPW-1:0] OP_HALT = 5'b00000;
    localparam logic [OPW-1:0] OP_J    = 5'b00100;
    localparam logic [OPW-1:0] OP_JR   = 5'b00101;
    localparam logic [OPW-1:0] OP_JAL  = 5'b00110;
    localparam logic [OPW-1:0] OP_JALR = 5'b00111;
    localparam logic [OPW-1:0] OP_BEQZ = 5'b01100;
    localparam logic [OPW-1:0] OP_BNEZ = 5'b01101;
    localparam logic [OPW-1:0] OP_BLTZ = 5'b01111;

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   if_instr_q, if_instr_d;
    logic [XLEN-1:0]   if_pc_inc_q, if_pc_inc_d;
    logic              if_valid_q, if_valid_d;
    logic              halted_q, halted_d;
    logic              squash_q, squash_d;
    logic [XLEN-1:0]   skid_q, skid_d;

    logic [OPW-1:0]    dec_op;
    logic              taken;
    logic              redirect;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_plus2;
    logic              halt_now;
    logic              fetch_done;
    logic [XLEN-1:0]   fetch_data;

    // Only the opcode field of the decode instruction matters here.
    logic unused_dec_bits;
    assign unused_dec_bits = ^dec_instr[10:0];

    assign dec_op   = dec_instr[15:11];
    assign pc_plus2 = pc_q + XLEN'(2);

    // Branch/jump resolution for the decode-stage instruction.
    always_comb begin
        taken  = 1'b0;
        target = brj_dest;
        case (dec_op)
            OP_BEQZ:         taken = (rs_val == '0);
            OP_BNEZ:         taken = (rs_val != '0);
            OP_BLTZ:         taken = rs_val[XLEN-1];
            OP_J, OP_JAL:    taken = 1'b1;
            OP_JR, OP_JALR: begin
                taken  = 1'b1;
                target = jr_dest;
            end
            default:         taken = 1'b0;
        endcase
        redirect = dec_valid && !stall_in && taken;
    end

    assign halt_now = if_valid_q && (if_instr_q[15:11] == OP_HALT) && !stall_in
                      && !redirect && (state_q != ST_HALTED);

    // Next-state logic: fetch FSM, IF/ID update, redirect and halt.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        if_instr_d  = if_instr_q;
        if_pc_inc_d = if_pc_inc_q;
        if_valid_d  = if_valid_q;
        halted_d    = halted_q;
        squash_d    = squash_q;
        skid_d      = skid_q;
        fetch_done  = 1'b0;
        fetch_data  = imem_rdata;

        case (state_q)
            ST_REQ: begin
                state_d = ST_WAIT;
                if (redirect) begin
                    pc_d     = target;
                    squash_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (imem_ready) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = ST_REQ;
                        if (redirect) pc_d = target;
                    end else if (redirect) begin
                        pc_d    = target;
                        state_d = ST_REQ;
                    end else if (!stall_in) begin
                        fetch_done = 1'b1;
                        state_d    = ST_REQ;
                    end else begin
                        skid_d  = imem_rdata;
                        state_d = ST_HOLD;
                    end
                end else if (redirect) begin
                    pc_d     = target;
                    squash_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (!stall_in) begin
                    state_d = ST_REQ;
                    if (redirect) begin
                        pc_d = target;
                    end else begin
                        fetch_done = 1'b1;
                        fetch_data = skid_q;
                    end
                end
            end
            default: begin
                // Halted: everything frozen until reset.
            end
        endcase

        if (fetch_done) begin
            if_instr_d  = fetch_data;
            if_pc_inc_d = pc_plus2;
            if_valid_d  = 1'b1;
            pc_d        = pc_plus2;
        end else if (!stall_in && state_q != ST_HALTED) begin
            if_valid_d = 1'b0;
        end

        // Halt wins over any in-flight fetch, which is abandoned.
        if (halt_now) begin
            state_d     = ST_HALTED;
            halted_d    = 1'b1;
            if_valid_d  = 1'b0;
            pc_d        = pc_q;
            if_instr_d  = if_instr_q;
            if_pc_inc_d = if_pc_inc_q;
            squash_d    = squash_q;
            skid_d      = skid_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_REQ;
            pc_q        <= RESET_PC;
            if_instr_q  <= '0;
            if_pc_inc_q <= '0;
            if_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
            squash_q    <= 1'b0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            if_instr_q  <= if_instr_d;
            if_pc_inc_q <= if_pc_inc_d;
            if_valid_q  <= if_valid_d;
            halted_q    <= halted_d;
            squash_q    <= squash_d;
            skid_q      <= skid_d;
        end
    end

    assign imem_req  = (state_q == ST_REQ);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc_inc = if_pc_inc_q;
    assign if_valid  = if_valid_q;
    assign halted    = halted_q;
    assign flush     = redirect;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with an expected-value queue.
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_w = 1'b1;
    logic        imem_ready = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        stall_in = 1'b0;
    logic        dec_valid = 1'b0;
    logic [15:0] dec_instr = '0;
    logic [15:0] rs_val = '0;
    logic [15:0] brj_dest = '0;
    logic [15:0] jr_dest = '0;

    logic        req_a, flush_a, ifv_a, halt_a;
    logic [15:0] addr_a, pc_a, ifi_a, ifp_a;
    logic        req_b, flush_b, ifv_b, halt_b;
    logic [15:0] addr_b, pc_b, ifi_b, ifp_b;

    logic        sel = 1'b0;
    logic        o_req, o_flush, o_ifv, o_halt;
    logic [15:0] o_addr, o_pc, o_ifi, o_ifp;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_redirect_unit dut (
        .clk(clk), .rst(rst), .imem_req(req_a), .imem_addr(addr_a),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall_in(stall_in),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .rs_val(rs_val),
        .brj_dest(brj_dest), .jr_dest(jr_dest), .pc(pc_a), .if_instr(ifi_a),
        .if_pc_inc(ifp_a), .if_valid(ifv_a), .flush(flush_a), .halted(halt_a)
    );

    fetch_redirect_unit #(.RESET_PC(16'hFFFE)) dut_w (
        .clk(clk), .rst(rst_w), .imem_req(req_b), .imem_addr(addr_b),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall_in(stall_in),
        .dec_valid(dec_valid), .dec_instr(dec_instr), .rs_val(rs_val),
        .brj_dest(brj_dest), .jr_dest(jr_dest), .pc(pc_b), .if_instr(ifi_b),
        .if_pc_inc(ifp_b), .if_valid(ifv_b), .flush(flush_b), .halted(halt_b)
    );

    assign o_req   = sel ? req_b   : req_a;
    assign o_flush = sel ? flush_b : flush_a;
    assign o_ifv   = sel ? ifv_b   : ifv_a;
    assign o_halt  = sel ? halt_b  : halt_a;
    assign o_addr  = sel ? addr_b  : addr_a;
    assign o_pc    = sel ? pc_b    : pc_a;
    assign o_ifi   = sel ? ifi_b   : ifi_a;
    assign o_ifp   = sel ? ifp_b   : ifp_a;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        exp_q.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with an observed value.
    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: observed=%h expected=<queue empty>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
            end
        end
    endtask

    // Wait (bounded) for a request pulse and check its address.
    task automatic wait_req(input logic [15:0] addr);
        for (int i = 0; i < 8 && !o_req; i++) tick();
        push(16'd1);
        push(addr);
        chk("req_seen", 16'(o_req));
        chk("imem_addr", o_addr);
    endtask

    // One complete fetch: request, one-cycle memory answer, IF/ID load.
    task automatic fetch(input logic [15:0] addr, input logic [15:0] data);
        wait_req(addr);
        tick();
        push(16'd0);
        chk("req_low_in_wait", 16'(o_req));
        imem_ready = 1'b1;
        imem_rdata = data;
        push(16'd1);
        push(data);
        push(16'(addr + 16'd2));
        push(16'(addr + 16'd2));
        tick();
        imem_ready = 1'b0;
        chk("if_valid", 16'(o_ifv));
        chk("if_instr", o_ifi);
        chk("if_pc_inc", o_ifp);
        chk("pc", o_pc);
    endtask

    initial begin
        // Reset
        tick();
        tick();
        push(16'h0000); push(16'd0); push(16'd0); push(16'd0); push(16'd0);
        chk("rst_pc", o_pc);
        chk("rst_if_valid", 16'(o_ifv));
        chk("rst_halted", 16'(o_halt));
        chk("rst_if_instr", o_ifi);
        chk("rst_if_pc_inc", o_ifp);
        rst = 1'b0;
        #1;

        // Straight-line fetches
        fetch(16'h0000, 16'h8000);
        fetch(16'h0002, 16'h8002);
        fetch(16'h0004, 16'h8004);

        // Stall while a fetch returns
        stall_in = 1'b1;
        wait_req(16'h0006);
        tick();
        imem_ready = 1'b1;
        imem_rdata = 16'h8006;
        tick();
        imem_ready = 1'b0;
        tick();
        tick();
        push(16'h8004); push(16'd1); push(16'h0006); push(16'd0);
        chk("stall_if_instr", o_ifi);
        chk("stall_if_valid", 16'(o_ifv));
        chk("stall_pc", o_pc);
        chk("stall_no_req", 16'(o_req));
        stall_in = 1'b0;
        tick();
        push(16'h8006); push(16'd1); push(16'h0008); push(16'h0008);
        chk("skid_if_instr", o_ifi);
        chk("skid_if_valid", 16'(o_ifv));
        chk("skid_if_pc_inc", o_ifp);
        chk("skid_pc", o_pc);

        // Taken BEQZ while waiting on 0008
        wait_req(16'h0008);
        tick();
        dec_valid = 1'b1;
        dec_instr = 16'b01100_00000000000;
        rs_val    = 16'h0000;
        brj_dest  = 16'h0040;
        jr_dest   = 16'h5555;
        #1;
        push(16'd1);
        chk("beqz_flush", 16'(o_flush));
        tick();
        dec_valid = 1'b0;
        push(16'd0); push(16'h0040);
        chk("beqz_if_valid", 16'(o_ifv));
        chk("beqz_pc", o_pc);
        imem_ready = 1'b1;
        imem_rdata = 16'h8008;
        tick();
        imem_ready = 1'b0;
        push(16'd0); push(16'h8006);
        chk("squash_if_valid", 16'(o_ifv));
        chk("squash_if_instr", o_ifi);
        wait_req(16'h0040);

        // Not-taken BNEZ, then JR
        dec_valid = 1'b1;
        dec_instr = 16'b01101_00000000000;
        rs_val    = 16'h0000;
        #1;
        push(16'd0);
        chk("bnez_flush", 16'(o_flush));
        fetch(16'h0040, 16'h8040);
        dec_instr = 16'b00101_00000000000;
        jr_dest   = 16'h1234;
        brj_dest  = 16'h0040;
        #1;
        push(16'd1);
        chk("jr_flush", 16'(o_flush));
        tick();
        dec_valid = 1'b0;
        imem_ready = 1'b1;
        imem_rdata = 16'h8042;
        tick();
        imem_ready = 1'b0;
        fetch(16'h1234, 16'h8234);

        // Halt
        fetch(16'h1236, 16'h0001);
        tick();
        push(16'd1); push(16'd0); push(16'd0); push(16'h1238);
        chk("halt_halted", 16'(o_halt));
        chk("halt_if_valid", 16'(o_ifv));
        chk("halt_no_req", 16'(o_req));
        chk("halt_pc", o_pc);
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b1;
            imem_rdata = 16'h8888;
            tick();
            imem_ready = 1'b0;
            push(16'd0); push(16'h1238); push(16'd1); push(16'h0001);
            chk("halted_no_req", 16'(o_req));
            chk("halted_pc", o_pc);
            chk("halted_sticky", 16'(o_halt));
            chk("halted_if_instr", o_ifi);
        end

        // Halt cancelled by a same-cycle redirect
        rst = 1'b1;
        tick();
        push(16'd0);
        chk("rst_clears_halt", 16'(o_halt));
        rst = 1'b0;
        fetch(16'h0000, 16'h0001);
        dec_valid = 1'b1;
        dec_instr = 16'b00100_00000000000;
        brj_dest  = 16'h0100;
        #1;
        push(16'd1);
        chk("j_flush", 16'(o_flush));
        tick();
        dec_valid = 1'b0;
        push(16'd0); push(16'd0); push(16'h0100);
        chk("flushed_halt_halted", 16'(o_halt));
        chk("flushed_halt_if_valid", 16'(o_ifv));
        chk("flushed_halt_pc", o_pc);
        imem_ready = 1'b1;
        imem_rdata = 16'h8002;
        tick();
        imem_ready = 1'b0;
        wait_req(16'h0100);
        push(16'd0);
        chk("flushed_halt_still_0", 16'(o_halt));

        // Wrap and mid-transaction reset on the FFFE instance
        rst   = 1'b1;
        sel   = 1'b1;
        rst_w = 1'b0;
        #1;
        fetch(16'hFFFE, 16'h8FFE);
        wait_req(16'h0000);
        tick();
        rst_w = 1'b1;
        tick();
        rst_w = 1'b0;
        push(16'hFFFE); push(16'd0);
        chk("wrst_pc", o_pc);
        chk("wrst_if_valid", 16'(o_ifv));
        imem_ready = 1'b1;
        imem_rdata = 16'h8AAA;
        tick();
        imem_ready = 1'b0;
        push(16'd0); push(16'hFFFE); push(16'd0); push(16'h0000);
        chk("late_ready_req", 16'(o_req));
        chk("late_ready_pc", o_pc);
        chk("late_ready_if_valid", 16'(o_ifv));
        chk("late_ready_if_instr", o_ifi);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Instruction-fetch front end of the 16-bit pipeline.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Holds the IF/ID pipeline register and supplies the IF/ID pc_inc that the branch/jump target adder consumes.
- Resolves branch/jump redirects coming back from decode, using that adder's destination plus the Rs value, and squashes the wrong path.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  one-cycle request pulse
- imem_addr  out  16  request address (= pc)
- imem_ready  in  1  one-cycle pulse, imem_rdata valid
- imem_rdata  in  16  fetched instruction
- stall_in  in  1  decode not accepting; hold IF/ID and PC
- dec_valid  in  1  dec_instr is a live decode-stage instruction
- dec_instr  in  16  decode-stage instruction (op = [15:11])
- rs_val  in  16  Rs operand of dec_instr
- brj_dest  in  16  PC-relative target for dec_instr
- jr_dest  in  16  register-relative target for JR/JALR
- pc  out  16  current fetch PC
- if_instr  out  16  IF/ID instruction
- if_pc_inc  out  16  IF/ID address + 2
- if_valid  out  1  IF/ID holds a live instruction
- flush  out  1  combinational, redirect taken this cycle
- halted  out  1  sticky halt

Behaviour:
- Reset values:
  - pc = RESET_PC; if_instr = 0; if_pc_inc = 0; if_valid = 0; halted = 0.
  - squash = 0; skid empty; state = REQ.
  - rst mid-transaction drops any in-flight request. An imem_ready arriving after reset while in REQ is ignored.
- Redirect (evaluated only when dec_valid=1 and stall_in=0; otherwise redirect = 0):
  - BEQZ 01100: taken if rs_val == 0, target brj_dest.
  - BNEZ 01101: taken if rs_val != 0, target brj_dest.
  - BLTZ 01111: taken if rs_val[15] == 1, target brj_dest.
  - J 00100 and JAL 00110: always taken, target brj_dest.
  - JR 00101 and JALR 00111: always taken, target jr_dest.
  - All other opcodes: never taken.
  - flush = redirect. On redirect, if_valid <= 0 next cycle regardless of any fetch completing.
- State machine:
  - REQ:
    - imem_req = 1, imem_addr = pc, then go to WAIT.
    - If redirect this cycle: pc <= target, squash <= 1.
  - WAIT (imem_req = 0). Redirect: pc <= target, squash <= 1. On imem_ready:
    - squash = 1: drop the data, squash <= 0, go to REQ.
    - Else if redirect: drop the data, go to REQ.
    - Else if stall_in = 0: if_instr <= rdata, if_pc_inc <= pc + 2, if_valid <= 1, pc <= pc + 2, go to REQ.
    - Else (stall_in = 1): capture rdata into skid, go to HOLD.
  - HOLD:
    - stall_in = 1: hold everything.
    - stall_in = 0 with redirect: discard skid, pc <= target, go to REQ.
    - stall_in = 0 without redirect: load IF/ID from skid, pc <= pc + 2, go to REQ.
  - HALTED: imem_req = 0, all registers frozen. Only rst exits.
- IF/ID bubbles:
  - stall_in = 0 and no fetch completes this cycle: if_valid <= 0.
  - stall_in = 1: IF/ID and pc hold, except pc updates on redirect, which cannot occur while stalled.
- Halt:
  - Condition: if_valid = 1, if_instr[15:11] = 00000, stall_in = 0, no redirect that cycle.
  - Effect: halted <= 1, if_valid <= 0, go to HALTED.
  - An in-flight fetch is abandoned.
  - A HALT flushed by a same-cycle redirect has no effect.
- Arithmetic:
  - pc + 2 is a 16-bit wrap: 16'hFFFE + 2 = 16'h0000.
  - Targets are used unmodified; alignment is not checked.
- Only one request is outstanding at a time; imem_ready outside WAIT is ignored.

Test Plan:
- Straight-line:
  - Stimulus: reset, then memory answers 1 cycle after each request.
  - Required: imem_addr 0000, 0002, 0004; if_pc_inc 0002, 0004, 0006; if_valid = 1 each accepted fetch; imem_req one pulse per request.
- Stall:
  - Stimulus: stall_in = 1 for 3 cycles while a fetch returns.
  - Required: IF/ID and pc unchanged. On release, skid data loaded, pc advances by 2. No lost or duplicated instruction.
- Taken branch:
  - Stimulus: dec_instr = BEQZ, rs_val = 0, brj_dest = 0040, issued while WAIT on address 0008.
  - Required: flush = 1, if_valid = 0 next cycle, returning 0008 data dropped, next imem_addr = 0040.
- Not taken, then JR:
  - Stimulus: BNEZ with rs_val = 0 → no flush, sequential fetch continues. Then JR with jr_dest = 1234.
  - Required: next imem_addr = 1234.
- Halt:
  - Stimulus: if_instr = 0000_0xxx becomes valid with stall_in = 0.
  - Required: halted = 1, no further imem_req, outputs frozen until rst. Same scenario with a concurrent redirect → halted stays 0.
- Wrap and reset:
  - Stimulus: RESET_PC = FFFE, fetch accepted.
  - Required: pc = 0000. Assert rst during WAIT → pc = FFFE, if_valid = 0, a late imem_ready ignored.
